// File: rtl/axil_regfile_if.sv
// AXI4-Lite bus bundle for axil_regfile: AW, W, B, AR and R channels
// with master and slave views.
interface axil_regfile_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0]  awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDRESS_WIDTH-1:0]  araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_regfile.sv
// AXI4-Lite register file with independent one-entry AW/W buffers and byte-strobe writes.
// Optional macro AXIL_REGFILE_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axil_regfile #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 8,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                           axi_aclk_in,
  input  logic                           axi_aresetn_in,
  axil_regfile_if.slave                  s_axil,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse_out
);
  localparam int STRBW = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(STRBW);
  localparam int IDXW  = ADDRESS_WIDTH - LSB;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  logic                     r_aw_full;
  logic [ADDRESS_WIDTH-1:0] r_aw_addr;
  logic                     r_w_full;
  logic [DATA_WIDTH-1:0]    r_w_data;
  logic [STRBW-1:0]         r_w_strb;
  logic                     r_bvalid;
  logic [1:0]               r_bresp;
  logic                     r_rvalid;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [1:0]               r_rresp;
  logic [DATA_WIDTH-1:0]    r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]      r_pulse;

  logic                     w_aw_hs;
  logic                     w_w_hs;
  logic                     w_ar_hs;
  logic                     w_commit;
  logic [ADDRESS_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0]    w_wr_data;
  logic [STRBW-1:0]         w_wr_strb;
  logic [IDXW-1:0]          w_wr_idx;
  logic [IDXW-1:0]          w_rd_idx;
  logic                     w_wr_hit;
  logic                     w_rd_hit;
  logic [DATA_WIDTH-1:0]    w_rd_val;
  logic                     w_unused;

  assign s_axil.awready   = !r_aw_full;
  assign s_axil.wready    = !r_w_full;
  assign s_axil.arready   = !r_rvalid || s_axil.rready;
  assign s_axil.bvalid    = r_bvalid;
  assign s_axil.bresp     = r_bresp;
  assign s_axil.rvalid    = r_rvalid;
  assign s_axil.rdata     = r_rdata;
  assign s_axil.rresp     = r_rresp;
  assign reg_wr_pulse_out = r_pulse;

  assign w_unused = ^{s_axil.awprot, s_axil.arprot, w_wr_addr[LSB-1:0], s_axil.araddr[LSB-1:0]};

  // Write path: a buffered entry takes priority over the live channel.
  always_comb begin
    w_aw_hs   = s_axil.awvalid && !r_aw_full;
    w_w_hs    = s_axil.wvalid && !r_w_full;
    w_ar_hs   = s_axil.arvalid && s_axil.arready;
    w_wr_addr = r_aw_full ? r_aw_addr : s_axil.awaddr;
    w_wr_data = r_w_full ? r_w_data : s_axil.wdata;
    w_wr_strb = r_w_full ? r_w_strb : s_axil.wstrb;
    w_commit  = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs) && (!r_bvalid || s_axil.bready);
    w_wr_idx  = w_wr_addr[ADDRESS_WIDTH-1:LSB];
    w_rd_idx  = s_axil.araddr[ADDRESS_WIDTH-1:LSB];
    w_wr_hit  = ({1'b0, w_wr_idx} < (IDXW+1)'(NUM_REGS));
    w_rd_hit  = ({1'b0, w_rd_idx} < (IDXW+1)'(NUM_REGS));
  end

  // Read mux; out-of-range indices fall through to zero.
  always_comb begin
    w_rd_val = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rd_idx == IDXW'(i)) begin
        w_rd_val = r_regs[i];
      end else begin
        w_rd_val = w_rd_val;
      end
    end
  end

  // Flatten the register array onto the local-logic bus.
  always_comb begin
    regs_out = {(NUM_REGS*DATA_WIDTH){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_out[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
    end
  end

  // Buffers, response channels, register storage and write pulses.
  always_ff @(posedge axi_aclk_in) begin
    if (!axi_aresetn_in) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= {ADDRESS_WIDTH{1'b0}};
      r_w_full  <= 1'b0;
      r_w_data  <= {DATA_WIDTH{1'b0}};
      r_w_strb  <= {STRBW{1'b0}};
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_rvalid  <= 1'b0;
      r_rdata   <= {DATA_WIDTH{1'b0}};
      r_rresp   <= 2'b00;
      r_pulse   <= {NUM_REGS{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (w_commit) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_full <= 1'b1;
          r_aw_addr <= s_axil.awaddr;
        end
        if (w_w_hs) begin
          r_w_full <= 1'b1;
          r_w_data <= s_axil.wdata;
          r_w_strb <= s_axil.wstrb;
        end
      end

      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_hit ? 2'b00 : ERR_RESP;
      end else if (s_axil.bready) begin
        r_bvalid <= 1'b0;
      end

      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_val;
        r_rresp  <= w_rd_hit ? 2'b00 : ERR_RESP;
      end else if (s_axil.rready) begin
        r_rvalid <= 1'b0;
      end

      for (int i = 0; i < NUM_REGS; i++) begin
        r_pulse[i] <= w_commit && w_wr_hit && (w_wr_idx == IDXW'(i));
        for (int k = 0; k < STRBW; k++) begin
          if (w_commit && w_wr_hit && (w_wr_idx == IDXW'(i)) && w_wr_strb[k]) begin
            r_regs[i][8*k +: 8] <= w_wr_data[8*k +: 8];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_axil_regfile.sv
// Directed self-checking bench for axil_regfile (6-bit address so index 9 is reachable).
module tb_axil_regfile;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 6;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] EXP_ERR = 2'b10;
`else
  localparam logic [1:0] EXP_ERR = 2'b00;
`endif

  logic             clk;
  logic             rst_n;
  logic [NR*DW-1:0] regs_out;
  logic [NR-1:0]    pulse;
  int               checks;
  int               errors;
  int               b_hs_cnt;
  int               pulse_cnt;
  int               b0;
  int               p0;
  logic [NR*DW-1:0] snap;

  axil_regfile_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_regfile #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDRESS_WIDTH(AW)) dut (
    .axi_aclk_in      (clk),
    .axi_aresetn_in   (rst_n),
    .s_axil           (bus.slave),
    .regs_out         (regs_out),
    .reg_wr_pulse_out (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.bvalid && bus.bready) b_hs_cnt <= b_hs_cnt + 1;
    if (|pulse) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] reg_at(input int i);
    return regs_out[i*DW +: DW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_aw(input int idx);
    bus.awaddr  = AW'(idx * 4);
    bus.awvalid = 1'b1;
  endtask

  task automatic drive_w(input logic [DW-1:0] d, input logic [3:0] s);
    bus.wdata  = d;
    bus.wstrb  = s;
    bus.wvalid = 1'b1;
  endtask

  task automatic do_write(input int idx, input logic [DW-1:0] d, input logic [3:0] s);
    drive_aw(idx);
    drive_w(d, s);
    step();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
  endtask

  task automatic do_read(input int idx);
    bus.araddr  = AW'(idx * 4);
    bus.arvalid = 1'b1;
    step();
    bus.arvalid = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; b_hs_cnt = 0; pulse_cnt = 0;
    rst_n = 1'b0;
    bus.awaddr = '0; bus.awprot = 3'b000; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = 4'h0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = 3'b000; bus.arvalid = 1'b0; bus.rready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();
    check_eq("rst_awready", 64'(bus.awready), 64'd1);
    check_eq("rst_wready",  64'(bus.wready),  64'd1);
    check_eq("rst_arready", 64'(bus.arready), 64'd1);
    check_eq("rst_bvalid",  64'(bus.bvalid),  64'd0);
    check_eq("rst_rvalid",  64'(bus.rvalid),  64'd0);
    check_eq("rst_regs0",   64'(reg_at(0)),   64'd0);

    // Basic write and readback at index 2
    do_write(2, 32'hDEADBEEF, 4'hF);
    check_eq("wr2_reg",    64'(reg_at(2)),   64'hDEADBEEF);
    check_eq("wr2_pulse",  64'(pulse),       64'h04);
    check_eq("wr2_bvalid", 64'(bus.bvalid),  64'd1);
    check_eq("wr2_bresp",  64'(bus.bresp),   64'd0);
    step();
    check_eq("wr2_pulse_off",  64'(pulse),      64'h00);
    check_eq("wr2_bvalid_off", 64'(bus.bvalid), 64'd0);
    do_read(2);
    check_eq("rd2_rvalid", 64'(bus.rvalid), 64'd1);
    check_eq("rd2_rdata",  64'(bus.rdata),  64'hDEADBEEF);
    check_eq("rd2_rresp",  64'(bus.rresp),  64'd0);
    step();
    check_eq("rd2_rvalid_off", 64'(bus.rvalid), 64'd0);

    // Byte strobes
    do_write(1, 32'h11223344, 4'hF);
    do_write(1, 32'hAABBCCDD, 4'h5);
    check_eq("strb_reg1", 64'(reg_at(1)), 64'h11BB33DD);
    do_write(1, 32'hFFFFFFFF, 4'h0);
    check_eq("strb0_reg1",  64'(reg_at(1)),  64'h11BB33DD);
    check_eq("strb0_pulse", 64'(pulse),      64'h02);
    check_eq("strb0_bresp", 64'(bus.bresp),  64'd0);
    step();

    // AW first, W four cycles later
    drive_aw(3);
    step();
    bus.awvalid = 1'b0;
    check_eq("awfirst_awready_c1", 64'(bus.awready), 64'd0);
    step(); step(); step();
    check_eq("awfirst_awready_c4", 64'(bus.awready), 64'd0);
    check_eq("awfirst_bvalid_c4",  64'(bus.bvalid),  64'd0);
    check_eq("awfirst_reg_c4",     64'(reg_at(3)),   64'd0);
    drive_w(32'h5, 4'hF);
    step();
    bus.wvalid = 1'b0;
    check_eq("awfirst_reg",     64'(reg_at(3)),   64'h5);
    check_eq("awfirst_bvalid",  64'(bus.bvalid),  64'd1);
    check_eq("awfirst_awready", 64'(bus.awready), 64'd1);
    step();

    // W first, AW four cycles later
    drive_w(32'h5, 4'hF);
    step();
    bus.wvalid = 1'b0;
    check_eq("wfirst_wready_c1", 64'(bus.wready), 64'd0);
    step(); step(); step();
    check_eq("wfirst_reg_c4", 64'(reg_at(4)), 64'd0);
    drive_aw(4);
    step();
    bus.awvalid = 1'b0;
    check_eq("wfirst_reg",    64'(reg_at(4)),  64'h5);
    check_eq("wfirst_bvalid", 64'(bus.bvalid), 64'd1);
    check_eq("wfirst_wready", 64'(bus.wready), 64'd1);
    step();

    // Write backpressure: bready low for six cycles
    b0 = b_hs_cnt; p0 = pulse_cnt;
    bus.bready = 1'b0;
    drive_aw(5); drive_w(32'hA5A5A5A5, 4'hF);
    step();
    drive_aw(6); drive_w(32'hB6B6B6B6, 4'hF);
    step();
    drive_aw(7); drive_w(32'hC7C7C7C7, 4'hF);
    step(); step(); step(); step();
    check_eq("bp_awready", 64'(bus.awready), 64'd0);
    check_eq("bp_wready",  64'(bus.wready),  64'd0);
    check_eq("bp_bvalid",  64'(bus.bvalid),  64'd1);
    check_eq("bp_reg5",    64'(reg_at(5)),   64'hA5A5A5A5);
    check_eq("bp_reg6_hold", 64'(reg_at(6)), 64'd0);
    bus.bready = 1'b1;
    step();
    check_eq("bp_reg6",      64'(reg_at(6)),   64'hB6B6B6B6);
    check_eq("bp_awready_up", 64'(bus.awready), 64'd1);
    check_eq("bp_bvalid_cont", 64'(bus.bvalid), 64'd1);
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check_eq("bp_reg7", 64'(reg_at(7)), 64'hC7C7C7C7);
    step(); step();
    check_eq("bp_b_count",     64'(b_hs_cnt - b0),  64'd3);
    check_eq("bp_pulse_count", 64'(pulse_cnt - p0), 64'd3);

    // Read and write to the same register in one cycle
    drive_aw(2); drive_w(32'h12345678, 4'hF);
    bus.araddr = AW'(8); bus.arvalid = 1'b1;
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check_eq("rw_rdata_old", 64'(bus.rdata), 64'hDEADBEEF);
    check_eq("rw_reg_new",   64'(reg_at(2)), 64'h12345678);
    step();

    // Out-of-range index 9
    snap = regs_out;
    do_write(9, 32'hFFFFFFFF, 4'hF);
    check_eq("oor_bvalid", 64'(bus.bvalid), 64'd1);
    check_eq("oor_bresp",  64'(bus.bresp),  64'(EXP_ERR));
    check_eq("oor_pulse",  64'(pulse),      64'd0);
    check_eq("oor_regs_lo", regs_out[63:0],    snap[63:0]);
    check_eq("oor_regs_hi", regs_out[255:192], snap[255:192]);
    step();
    do_read(9);
    check_eq("oor_rvalid", 64'(bus.rvalid), 64'd1);
    check_eq("oor_rdata",  64'(bus.rdata),  64'd0);
    check_eq("oor_rresp",  64'(bus.rresp),  64'(EXP_ERR));
    step();

    // Reset with a buffered AW and a pending read response
    bus.rready = 1'b0;
    drive_aw(0);
    bus.araddr = AW'(8); bus.arvalid = 1'b1;
    step();
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    check_eq("mid_awready", 64'(bus.awready), 64'd0);
    check_eq("mid_rvalid",  64'(bus.rvalid),  64'd1);
    rst_n = 1'b0;
    step();
    check_eq("mrst_awready", 64'(bus.awready), 64'd1);
    check_eq("mrst_wready",  64'(bus.wready),  64'd1);
    check_eq("mrst_arready", 64'(bus.arready), 64'd1);
    check_eq("mrst_rvalid",  64'(bus.rvalid),  64'd0);
    check_eq("mrst_rdata",   64'(bus.rdata),   64'd0);
    check_eq("mrst_bvalid",  64'(bus.bvalid),  64'd0);
    check_eq("mrst_pulse",   64'(pulse),       64'd0);
    check_eq("mrst_regs_lo", regs_out[127:0],   128'd0);
    check_eq("mrst_regs_hi", regs_out[255:192], 64'd0);
    rst_n = 1'b1;
    bus.rready = 1'b1;
    step();
    do_write(0, 32'h00000077, 4'hF);
    check_eq("post_reg0",   64'(reg_at(0)),  64'h77);
    check_eq("post_bvalid", 64'(bus.bvalid), 64'd1);
    check_eq("post_pulse",  64'(pulse),      64'h01);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axil_regfile.md
# axil_regfile

Parametrised AXI4-Lite subordinate register file: NUM_REGS registers of DATA_WIDTH bits, each with byte-strobe writes and readback. It accepts AW and W independently, holding either one until its partner arrives. It sustains one write and one read per cycle and reports out-of-range accesses. It sits behind the interconnect as the generic control/status block and exposes every register, plus a per-register write strobe, to local logic.

## Interface
- DATA_WIDTH, 32: register and bus data width; 32 or 64.
- NUM_REGS, 8: number of registers; 1 to 2^(ADDRESS_WIDTH-log2(DATA_WIDTH/8)).
- ADDRESS_WIDTH, 5: AXI address width; register index = addr[ADDRESS_WIDTH-1:log2(DATA_WIDTH/8)], low bits ignored.
- Clocking and reset: one clock; reset is synchronous and active-low.
- axi_aclk_in  in  1  clock; all logic on rising edge.
- axi_aresetn_in  in  1  synchronous active-low reset.
- axi_awaddr_in/axi_awprot_in/axi_awvalid_in  in  ADDRESS_WIDTH/3/1  write address channel; prot ignored.
- axi_awready_out  out  1  write address ready.
- axi_wdata_in/axi_wstrb_in/axi_wvalid_in  in  DATA_WIDTH/DATA_WIDTH/8/1  write data channel.
- axi_wready_out  out  1  write data ready.
- axi_bresp_out/axi_bvalid_out  out  2/1; axi_bready_in  in  1  write response channel.
- axi_araddr_in/axi_arprot_in/axi_arvalid_in  in  ADDRESS_WIDTH/3/1; axi_arready_out  out  1  read address channel.
- axi_rdata_out/axi_rresp_out/axi_rvalid_out  out  DATA_WIDTH/2/1; axi_rready_in  in  1  read data channel.
- regs_out  out  NUM_REGS*DATA_WIDTH  register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- reg_wr_pulse_out  out  NUM_REGS  bit i high for exactly one cycle when register i is committed.

## Operation
- Reset (aresetn low at an edge): all registers 0; AW and W holding buffers empty; bvalid=0, bresp=00, rvalid=0, rresp=00, rdata=0, reg_wr_pulse_out=0. awready and wready read 1 and arready reads 1 in the cycle after reset.
- AW buffer: one entry. awready_out = AW buffer empty. An AW handshake with no commit in the same cycle loads the buffer.
- W buffer: one entry. It behaves the same way; wready_out = W buffer empty.
- Commit condition: an address is available (buffered, or AW handshake this cycle), data is available (buffered, or W handshake this cycle), and (!bvalid || bready).
- Commit: the indexed register updates byte-wise. Byte k takes wdata[8k+:8] if wstrb[k] is set, else keeps its value. Both buffers clear. The matching reg_wr_pulse_out bit rises in the next cycle. bvalid is set next cycle with bresp.
- An index >= NUM_REGS writes nothing and raises no pulse; bresp per Configuration.
- All-zero wstrb is a legal commit: the value is unchanged, the pulse still fires, and bresp is OKAY.
- B channel: bvalid stays high until bready. A commit in the same cycle as bready keeps bvalid high with the new bresp.
- Read: arready_out = !rvalid || rready. On an AR handshake, rdata and rresp latch the register value at that edge, and rvalid is set next cycle. rvalid/rdata/rresp are held stable while rvalid && !rready.
- A read and a write to the same register in the same cycle return the pre-write value.

## Timing
- Write latency: AW and W handshakes in cycle N → register and regs_out updated, pulse high, bvalid high in cycle N+1.
- AW in N, W in N+k → commit at N+k, bvalid at N+k+1. W-first is symmetric.
- With bready held high: one write per cycle; bvalid stays high continuously.
- With bready low and bvalid high: at most one AW and one W are buffered, then awready and wready drop. They recover the cycle after bready.
- Read latency is 1 cycle. With rready held high, one read per cycle.
- A reset mid-transaction drops buffered AW/W and any pending B/R response. No response is issued for them.

## Configuration
- AXIL_REGFILE_SLVERR_EN defined: an out-of-range write gets bresp=2'b10 (SLVERR). An out-of-range read returns rdata=0 with rresp=2'b10.
- Undefined: out-of-range writes are silently dropped with bresp=00. Reads return rdata=0 with rresp=00.
- In-range accesses are always OKAY.

## Test plan
- Defaults; AW+W together at index 2, data 0xDEADBEEF, wstrb 0xF, bready=1 → next cycle regs_out[2]=0xDEADBEEF, reg_wr_pulse_out=0x04 for one cycle, bvalid=1 with bresp=00. Read of index 2 → rdata=0xDEADBEEF one cycle after AR.
- Reg 1 = 0x11223344. Write 0xAABBCCDD with wstrb 0x5 → regs_out[1]=0x11BB33DD.
- AW at index 3 in cycle 0, W 0x5 in cycle 4 → awready=0 in cycles 1–4, register changes and bvalid rises at cycle 5. Repeat with W first; the result is the same.
- bready=0 for 6 cycles with a stream of writes → one commit, one AW and one W buffered, awready=wready=0. When bready rises, writes resume and each write gets exactly one B.
- Address index 9 with NUM_REGS=8: with AXIL_REGFILE_SLVERR_EN, bresp=10 and rresp=10 with rdata=0, and regs are unchanged. Without it, both responses are 00.
- Assert aresetn low during a cycle with a buffered AW and a pending rvalid → next cycle all outputs are at their reset values, and a new write completes normally afterwards.
